branch_sequencer: RTL and testbench

Hardwired control sequencer for the conditional-branch class (brzr, brnz, brpl, brmi) of the RISC datapath. It takes one start pulse and then drives the datapath's register-transfer strobes through instruction fetch, condition evaluation and the conditional PC update. It holds the CON flip-flop internally and waits on a memory-ready handshake during fetch. It sits beside the datapath, replacing bench-driven strobes, and is generalised in data width, opcode width, wait depth and ALU encodings.

---
 rtl/branch_seq_pkg.sv | 29 ++
 rtl/branch_cond.sv | 28 ++
 rtl/branch_sequencer.sv | 170 +++++++++++++++++
 tb/tb_branch_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_seq_pkg.sv
// Shared types and field positions for the conditional-branch control sequencer.
package branch_seq_pkg;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    T0   = 4'd1,
    T1   = 4'd2,
    T1M  = 4'd3,
    T2   = 4'd4,
    T3   = 4'd5,
    T4   = 4'd6,
    T5   = 4'd7,
    T6   = 4'd8,
    DONE = 4'd9
  } state_e;

  typedef enum logic [1:0] {
    C_ZR = 2'b00,
    C_NZ = 2'b01,
    C_PL = 2'b10,
    C_MI = 2'b11
  } c2_e;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int C2_HI  = 20;
  localparam int C2_LO  = 19;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator: zero / non-zero / positive / negative test of a bus value.
module branch_cond
  import branch_seq_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] bus,
  input  logic [1:0]        c2,
  output logic              cond
);

  logic zero;
  logic neg;

  always_comb begin
    zero = (bus == '0);
    neg  = bus[DATA_W-1];
    cond = 1'b0;
    case (c2_e'(c2))
      C_ZR:    cond = zero;
      C_NZ:    cond = !zero;
      C_PL:    cond = !zero && !neg;
      C_MI:    cond = neg;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// Hardwired control sequencer for brzr/brnz/brpl/brmi: fetch, condition evaluation
// into the CON flip-flop, and the conditional PC <- PC + C update.
module branch_sequencer
  import branch_seq_pkg::*;
#(
  parameter int         DATA_W   = 32,
  parameter int         OPC_W    = 5,
  parameter logic [4:0] BR_OPC   = 5'b10011,
  parameter int         ALU_INC  = 12,
  parameter int         ALU_ADD  = 2,
  parameter int         MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] bus,
  input  logic [DATA_W-1:0] ir,
  output logic              PCout,
  output logic              Zlowout,
  output logic              MDRout,
  output logic              MARin,
  output logic              Zin,
  output logic              PCin,
  output logic              MDRin,
  output logic              IRin,
  output logic              Yin,
  output logic              Read,
  output logic              Gra,
  output logic              Rout,
  output logic              CONin,
  output logic              Cout,
  output logic [OPC_W-1:0]  alu_op,
  output logic              busy,
  output logic              done,
  output logic              taken,
  output logic              err,
  output state_e            dbg_state
);

  localparam int WCW = $clog2(MAX_WAIT + 1);

  state_e         state_q, state_d;
  logic           con_q, con_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           cond_bit;
  logic           ir_unused;

  branch_cond #(.DATA_W(DATA_W)) u_cond (
    .bus  (bus),
    .c2   (ir[C2_HI:C2_LO]),
    .cond (cond_bit)
  );

  // Only the opcode and C2 fields are decoded; the reduction keeps the rest referenced.
  assign ir_unused = ^ir;

  assign taken     = con_q;
  assign dbg_state = state_q;

  // Memory handshake: the sequencer holds Read/MDRin for as long as it sits in T1M;
  // a high mem_ready at a rising edge in T1M completes the transfer (MDR captures
  // on that same edge). mem_ready has no effect in any other state.
  always_comb begin
    state_d    = state_q;
    con_d      = con_q;
    wait_cnt_d = wait_cnt_q;
    PCout      = 1'b0;
    Zlowout    = 1'b0;
    MDRout     = 1'b0;
    MARin      = 1'b0;
    Zin        = 1'b0;
    PCin       = 1'b0;
    MDRin      = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    Read       = 1'b0;
    Gra        = 1'b0;
    Rout       = 1'b0;
    CONin      = 1'b0;
    Cout       = 1'b0;
    alu_op     = '0;
    busy       = (state_q != IDLE);
    done       = 1'b0;
    err        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) state_d = T0;
      end
      T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        Zin     = 1'b1;
        alu_op  = OPC_W'(ALU_INC);
        state_d = T1;
      end
      T1: begin
        Zlowout    = 1'b1;
        PCin       = 1'b1;
        wait_cnt_d = '0;
        state_d    = T1M;
      end
      T1M: begin
        Read  = 1'b1;
        MDRin = 1'b1;
        if (mem_ready) begin
          state_d = T2;
        end else if (wait_cnt_q == WCW'(MAX_WAIT)) begin
          err     = 1'b1;
          state_d = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      T2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = T3;
      end
      T3: begin
        Gra   = 1'b1;
        Rout  = 1'b1;
        CONin = 1'b1;
        // A non-branch opcode aborts before CON is written so taken keeps its old value.
        if (ir[OPC_HI:OPC_LO] != BR_OPC) begin
          err     = 1'b1;
          state_d = IDLE;
        end else begin
          con_d   = cond_bit;
          state_d = T4;
        end
      end
      T4: begin
        PCout   = 1'b1;
        Yin     = 1'b1;
        state_d = T5;
      end
      T5: begin
        Cout    = 1'b1;
        Zin     = 1'b1;
        alu_op  = OPC_W'(ALU_ADD);
        state_d = con_q ? T6 : DONE;
      end
      T6: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q    <= IDLE;
      con_q      <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      con_q      <= con_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer against a phase-list reference model.
module tb_branch_sequencer;
  import branch_seq_pkg::*;

  localparam int         MAX_WAIT_TB = 15;
  localparam logic [4:0] BR_OPC_TB   = 5'b10011;
  localparam logic [4:0] ALU_INC_V   = 5'd12;
  localparam logic [4:0] ALU_ADD_V   = 5'd2;

  localparam logic [13:0] M_PCOUT  = 14'h2000;
  localparam logic [13:0] M_ZLOW   = 14'h1000;
  localparam logic [13:0] M_MDROUT = 14'h0800;
  localparam logic [13:0] M_MARIN  = 14'h0400;
  localparam logic [13:0] M_ZIN    = 14'h0200;
  localparam logic [13:0] M_PCIN   = 14'h0100;
  localparam logic [13:0] M_MDRIN  = 14'h0080;
  localparam logic [13:0] M_IRIN   = 14'h0040;
  localparam logic [13:0] M_YIN    = 14'h0020;
  localparam logic [13:0] M_READ   = 14'h0010;
  localparam logic [13:0] M_GRA    = 14'h0008;
  localparam logic [13:0] M_ROUT   = 14'h0004;
  localparam logic [13:0] M_CONIN  = 14'h0002;
  localparam logic [13:0] M_COUT   = 14'h0001;

  logic        clk;
  logic        clr;
  logic        start;
  logic        mem_ready;
  logic [31:0] bus;
  logic [31:0] ir;
  logic        PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin;
  logic        Read, Gra, Rout, CONin, Cout;
  logic [4:0]  alu_op;
  logic        busy, done, taken, err;
  state_e      dbg_state;

  int          n_pass;
  int          n_total;
  logic        model_con;
  logic [19:0] exp_q[$];

  branch_sequencer #(
    .DATA_W(32), .OPC_W(5), .BR_OPC(BR_OPC_TB),
    .ALU_INC(12), .ALU_ADD(2), .MAX_WAIT(MAX_WAIT_TB)
  ) dut (
    .clk(clk), .clr(clr), .start(start), .mem_ready(mem_ready), .bus(bus), .ir(ir),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin), .Zin(Zin),
    .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Read(Read), .Gra(Gra),
    .Rout(Rout), .CONin(CONin), .Cout(Cout), .alu_op(alu_op), .busy(busy),
    .done(done), .taken(taken), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [19:0] rec(input logic [13:0] s, input logic [4:0] a, input logic d);
    return {s, a, d};
  endfunction

  function automatic logic [19:0] obs();
    return {PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
            Read, Gra, Rout, CONin, Cout, alu_op, done};
  endfunction

  // Reference condition: plain signed/unsigned arithmetic on the bus value.
  function automatic logic model_cond(input logic [31:0] b, input logic [1:0] c);
    case (c)
      2'b00:   return b == 32'd0;
      2'b01:   return b != 32'd0;
      2'b10:   return $signed(b) > 0;
      default: return $signed(b) < 0;
    endcase
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] opc, input logic [1:0] c2);
    logic [31:0] r;
    r = $urandom;
    r[31:27] = opc;
    r[20:19] = c2;
    return r;
  endfunction

  // driver + scoreboard for one complete branch sequence
  task automatic run_seq(input logic [31:0] ir_v, input logic [31:0] bus_v, input int waits,
                         input int busy_start_cyc, input string name);
    logic [19:0] got_q[$];
    logic legal, tk, tout, exp_err;
    int   n_t1m, rd_cnt, n_err, n_done, done_at, exp_lat;
    legal = (ir_v[31:27] == BR_OPC_TB);
    tk    = model_cond(bus_v, ir_v[20:19]);
    tout  = (waits > MAX_WAIT_TB);
    n_t1m = tout ? MAX_WAIT_TB + 1 : waits + 1;
    exp_q.delete();
    exp_q.push_back(rec(M_PCOUT | M_MARIN | M_ZIN, ALU_INC_V, 1'b0));
    exp_q.push_back(rec(M_ZLOW | M_PCIN, 5'd0, 1'b0));
    for (int i = 0; i < n_t1m; i++) exp_q.push_back(rec(M_READ | M_MDRIN, 5'd0, 1'b0));
    if (!tout) begin
      exp_q.push_back(rec(M_MDROUT | M_IRIN, 5'd0, 1'b0));
      exp_q.push_back(rec(M_GRA | M_ROUT | M_CONIN, 5'd0, 1'b0));
      if (legal) begin
        exp_q.push_back(rec(M_PCOUT | M_YIN, 5'd0, 1'b0));
        exp_q.push_back(rec(M_COUT | M_ZIN, ALU_ADD_V, 1'b0));
        if (tk) exp_q.push_back(rec(M_ZLOW | M_PCIN, 5'd0, 1'b0));
        exp_q.push_back(rec(14'd0, 5'd0, 1'b1));
      end
    end
    exp_err = tout || !legal;
    exp_lat = legal && !tout ? (tk ? 8 : 7) + waits : -1;
    if (!tout && legal) model_con = tk;

    ir = ir_v;
    bus = bus_v;
    start = 1'b1;
    @(posedge clk);
    rd_cnt = 0; n_err = 0; n_done = 0; done_at = -1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      #1;
      start = (cyc == busy_start_cyc);
      mem_ready = Read ? (rd_cnt >= waits) : 1'($urandom_range(0, 1));
      #1;
      if (!busy) break;
      got_q.push_back(obs());
      if (err) n_err++;
      if (done) begin n_done++; done_at = cyc - 1; end
      if (Read) rd_cnt++;
      @(posedge clk);
    end
    start = 1'b0;
    mem_ready = 1'b0;

    n_total++;
    if (got_q.size() !== exp_q.size())
      $display("FAIL %s busy_cycles got %0d exp %0d", name, got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_total++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL %s cyc%0d strobes/alu/done got %h exp %h", name, i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    n_total++;
    if (n_err !== (exp_err ? 1 : 0))
      $display("FAIL %s err_pulses got %0d exp %0d", name, n_err, exp_err ? 1 : 0);
    else n_pass++;
    n_total++;
    if (done_at !== exp_lat)
      $display("FAIL %s done_latency got %0d exp %0d", name, done_at, exp_lat);
    else n_pass++;
    n_total++;
    if (n_done !== (exp_lat >= 0 ? 1 : 0))
      $display("FAIL %s done_pulses got %0d exp %0d", name, n_done, exp_lat >= 0 ? 1 : 0);
    else n_pass++;
    n_total++;
    if (taken !== model_con)
      $display("FAIL %s taken got %b exp %b", name, taken, model_con);
    else n_pass++;
  endtask

  task automatic check_idle(input string name);
    n_total++;
    if (obs() !== 20'd0 || busy !== 1'b0 || err !== 1'b0)
      $display("FAIL %s outputs got %h busy %b err %b exp 0", name, obs(), busy, err);
    else n_pass++;
    n_total++;
    if (dbg_state !== IDLE) $display("FAIL %s state got %0d exp IDLE", name, dbg_state);
    else n_pass++;
    n_total++;
    if (taken !== model_con) $display("FAIL %s taken got %b exp %b", name, taken, model_con);
    else n_pass++;
  endtask

  task automatic test_reset();
    clr = 1'b0; start = 1'b1; mem_ready = 1'b1; bus = 32'd9; ir = 32'h9B080019;
    repeat (3) @(posedge clk);
    #1;
    model_con = 1'b0;
    check_idle("reset");
    clr = 1'b1; start = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    check_idle("reset_release");
  endtask

  task automatic test_brnz_taken();
    run_seq(32'h9B080019, 32'd9, 0, -1, "brnz_taken");
  endtask

  task automatic test_brnz_not_taken();
    run_seq(32'h9B080019, 32'd0, 0, -1, "brnz_not_taken");
  endtask

  task automatic test_cond_matrix();
    logic [31:0] vals[3];
    vals[0] = 32'd0; vals[1] = 32'd5; vals[2] = 32'h80000000;
    for (int c = 0; c < 4; c++)
      for (int v = 0; v < 3; v++)
        run_seq(mk_ir(BR_OPC_TB, 2'(c)), vals[v], 0, -1, $sformatf("cond_c%0d_v%0d", c, v));
  endtask

  task automatic test_mem_wait();
    run_seq(32'h9B080019, 32'd9, 3, -1, "mem_wait3");
    run_seq(mk_ir(BR_OPC_TB, 2'b11), 32'd7, MAX_WAIT_TB, -1, "mem_wait_max");
  endtask

  task automatic test_timeout();
    run_seq(32'h9B080019, 32'd9, 1000, -1, "mem_timeout");
  endtask

  task automatic test_illegal_opcode();
    run_seq(mk_ir(BR_OPC_TB, 2'b01), 32'd3, 0, -1, "illegal_prep");
    run_seq(mk_ir(5'b00011, 2'b00), 32'd5, 0, -1, "illegal_opc");
  endtask

  task automatic test_reset_midseq();
    ir = 32'h9B080019; bus = 32'd9; mem_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_total++;
    if (obs() !== rec(M_PCOUT | M_YIN, 5'd0, 1'b0))
      $display("FAIL reset_mid at_T4 got %h exp %h", obs(), rec(M_PCOUT | M_YIN, 5'd0, 1'b0));
    else n_pass++;
    clr = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
    mem_ready = 1'b0;
    model_con = 1'b0;
    check_idle("reset_mid");
    @(posedge clk); #1;
    check_idle("reset_mid_after");
  endtask

  task automatic test_start_while_busy();
    run_seq(32'h9B080019, 32'd9, 0, 3, "start_in_T2");
    run_seq(32'h9B080019, 32'd0, 1, 9, "start_in_DONE");
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    d1 = -1; d2 = -1;
    ir = 32'h9B080019; bus = 32'd9; mem_ready = 1'b1; start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      #1;
      if (done) begin
        if (d1 < 0) d1 = cyc;
        else begin d2 = cyc; start = 1'b0; end
      end
      if (d2 >= 0) break;
      @(posedge clk);
    end
    start = 1'b0;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    model_con = 1'b1;
    n_total++;
    if (d1 !== 9) $display("FAIL b2b first_done got %0d exp 9", d1);
    else n_pass++;
    n_total++;
    if (d2 - d1 !== 10) $display("FAIL b2b done_spacing got %0d exp 10", d2 - d1);
    else n_pass++;
    check_idle("b2b_end");
  endtask

  task automatic test_random();
    logic [31:0] b;
    logic [4:0]  opc;
    int          bsc;
    for (int n = 0; n < 25; n++) begin
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'd1;
        2: b = 32'hFFFFFFFF;
        3: b = 32'h80000000;
        default: b = $urandom;
      endcase
      opc = ($urandom_range(0, 5) == 0) ? 5'($urandom) : BR_OPC_TB;
      bsc = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 9) : -1;
      run_seq(mk_ir(opc, 2'($urandom)), b, $urandom_range(0, 4), bsc, $sformatf("rand%0d", n));
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0; model_con = 1'b0;
    clr = 1'b0; start = 1'b0; mem_ready = 1'b0; bus = '0; ir = '0;
    test_reset();
    test_brnz_taken();
    test_brnz_not_taken();
    test_cond_matrix();
    test_mem_wait();
    test_timeout();
    test_illegal_opcode();
    test_reset_midseq();
    test_start_while_busy();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
